// File: rtl/dct_blk_sched_if.sv
// ============================================================================
// Module : dct_blk_sched_if
// Brief  : Pixel-in / DCT-core / framed-coefficient signal bundle for dct_blk_sched.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dct_blk_sched_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  xin;
    logic        dct_rdy;
    logic [11:0] dct_in;
    logic [11:0] coef_out;
    logic        coef_valid;
    logic        coef_sop;
    logic        coef_eop;
    logic        busy;
    logic        err;

    // Pixel source, DCT core and coefficient sink seen as one environment
    modport master (
        output pix_in, pix_valid, dct_rdy, dct_in,
        input  pix_ready, xin, coef_out, coef_valid, coef_sop, coef_eop, busy, err
    );

    modport slave (
        input  pix_in, pix_valid, dct_rdy, dct_in,
        output pix_ready, xin, coef_out, coef_valid, coef_sop, coef_eop, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/dct_blk_sched.sv
// ============================================================================
// Module : dct_blk_sched
// Brief  : Buffers 64 pixels into an 8x8 block, bursts them to the DCT core and
//          frames the returned coefficients. Optional macro: DCT_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dct_blk_sched #(
    parameter int PIPE_LAT = 94,
    parameter int TO_MAX   = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    dct_blk_sched_if.slave bus
);

    localparam int LAT_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
    localparam int TO_W  = (TO_MAX < 2) ? 1 : $clog2(TO_MAX + 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FEED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_buf [0:63];
    logic [5:0]        r_wr_cnt;
    logic [5:0]        r_rd_cnt;
    logic [5:0]        r_out_cnt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_lat_run;
    logic              r_emit;
    logic              r_pix_ready;
    logic [7:0]        r_xin;
    logic [11:0]       r_coef;
    logic              r_coef_valid;
    logic              r_coef_sop;
    logic              r_coef_eop;
    logic              r_err;

    logic              w_wr_en;
    logic              w_feed_first;
    logic              w_lat_done;
    logic              w_emit_go;
    logic              w_timeout;
    logic              w_cap;

    always_comb begin
        w_next       = r_state;
        w_wr_en      = 1'b0;
        w_feed_first = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_wr_en = bus.pix_valid & r_pix_ready;
                if (w_wr_en && (r_wr_cnt == 6'd63)) begin
                    w_next = ST_FEED;
                end
            end
            ST_FEED: begin
                w_feed_first = (r_rd_cnt == 6'd0);
                if (r_rd_cnt == 6'd63) begin
                    w_next = ST_FILL;
                end
            end
            default: w_next = ST_FILL;
        endcase
    end

    assign w_lat_done = r_lat_run & (r_lat_cnt == '0);

`ifdef DCT_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    assign w_emit_go = w_lat_done & bus.dct_rdy;
    assign w_timeout = w_lat_done & ~bus.dct_rdy & (r_to_cnt == TO_W'(TO_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_feed_first) begin
                r_to_cnt <= '0;
            end else if (w_lat_done && !bus.dct_rdy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;

    // The core is free-running here: whatever it presents at lat_cnt=0 is framed
    assign w_emit_go    = w_lat_done;
    assign w_timeout    = 1'b0;
    assign r_err        = 1'b0;
    assign w_unused_cfg = bus.dct_rdy ^ (TO_W == 0);
`endif

    // Emission captures from the go cycle onward, so coef_out lags dct_in by one cycle
    assign w_cap = w_emit_go | r_emit;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_cnt] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_pix_ready  <= 1'b0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_out_cnt    <= '0;
            r_lat_cnt    <= '0;
            r_lat_run    <= 1'b0;
            r_emit       <= 1'b0;
            r_xin        <= '0;
            r_coef       <= '0;
            r_coef_valid <= 1'b0;
            r_coef_sop   <= 1'b0;
            r_coef_eop   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pix_ready <= (w_next == ST_FILL);

            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 6'd1;
            end

            if (r_state == ST_FEED) begin
                r_xin    <= r_buf[r_rd_cnt];
                r_rd_cnt <= r_rd_cnt + 6'd1;
            end

            // Reload is independent of an emission that may still be running
            if (w_feed_first) begin
                r_lat_cnt <= LAT_W'(PIPE_LAT);
                r_lat_run <= 1'b1;
            end else if (r_lat_run) begin
                if (r_lat_cnt != '0) begin
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                end else if (w_emit_go || w_timeout) begin
                    r_lat_run <= 1'b0;
                end
            end

            r_coef_valid <= w_cap;
            r_coef_sop   <= w_cap & (r_out_cnt == 6'd0);
            r_coef_eop   <= w_cap & (r_out_cnt == 6'd63);
            if (w_cap) begin
                r_coef    <= bus.dct_in;
                r_out_cnt <= r_out_cnt + 6'd1;
            end

            if (w_emit_go) begin
                r_emit <= 1'b1;
            end else if (w_cap && (r_out_cnt == 6'd63)) begin
                r_emit <= 1'b0;
            end
        end
    end

    assign bus.pix_ready  = r_pix_ready;
    assign bus.xin        = r_xin;
    assign bus.coef_out   = r_coef;
    assign bus.coef_valid = r_coef_valid;
    assign bus.coef_sop   = r_coef_sop;
    assign bus.coef_eop   = r_coef_eop;
    assign bus.busy       = (r_state == ST_FEED) | r_lat_run | r_emit;
    assign bus.err        = r_err;

endmodule

`default_nettype wire
